// File: rtl/m_mmr_arbiter.sv
// Round-robin arbiter sharing the MMR register file between the CPU and DMA ports.
// Range-checks each access, strobes the MMR interface for one cycle, returns a registered ack.
module m_mmr_arbiter #(
    parameter int AW        = 12,
    parameter int DW        = 16,
    parameter int MMR_BASE  = 1025,
    parameter int MMR_COUNT = 75,
    parameter int SW        = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic          cpu_err,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic          dma_err,
    output logic [DW-1:0] dma_rdata,
    output logic          mmr_en,
    output logic          mmr_we,
    output logic [SW-1:0] mmr_sel,
    output logic [DW-1:0] mmr_wdata,
    input  logic [DW-1:0] mmr_rdata,
    output logic [7:0]    err_count
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [AW:0] BASE_W = (AW+1)'(MMR_BASE);
    localparam logic [AW:0] LAST_W = (AW+1)'(MMR_BASE + MMR_COUNT - 1);

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;       // 0 = CPU has priority, 1 = DMA
    logic          gnt_q, gnt_d;       // 0 = CPU granted, 1 = DMA granted
    logic          mmr_en_q, mmr_en_d;
    logic          mmr_we_q, mmr_we_d;
    logic [SW-1:0] mmr_sel_q, mmr_sel_d;
    logic [DW-1:0] mmr_wdata_q, mmr_wdata_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          cpu_err_q, cpu_err_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic          dma_ack_q, dma_ack_d;
    logic          dma_err_q, dma_err_d;
    logic [DW-1:0] dma_rdata_q, dma_rdata_d;
    logic [7:0]    err_count_q, err_count_d;

    logic          pick_dma;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_in_range;
    logic [SW-1:0] req_sel;

    always_comb begin
        pick_dma     = dma_req && (!cpu_req || ptr_q);
        req_we       = pick_dma ? dma_we    : cpu_we;
        req_addr     = pick_dma ? dma_addr  : cpu_addr;
        req_wdata    = pick_dma ? dma_wdata : cpu_wdata;
        req_in_range = ({1'b0, req_addr} >= BASE_W) && ({1'b0, req_addr} <= LAST_W);
        req_sel      = SW'(req_addr - AW'(MMR_BASE));
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        mmr_en_d    = 1'b0;
        mmr_we_d    = 1'b0;
        mmr_sel_d   = '0;
        mmr_wdata_d = '0;
        cpu_ack_d   = 1'b0;
        cpu_err_d   = 1'b0;
        cpu_rdata_d = '0;
        dma_ack_d   = 1'b0;
        dma_err_d   = 1'b0;
        dma_rdata_d = '0;
        err_count_d = err_count_q;

        unique case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    gnt_d = pick_dma;
                    ptr_d = !pick_dma;
                    if (req_in_range) begin
                        // MMR strobe registers double as the latched request for ACCESS
                        state_d     = ACCESS;
                        mmr_en_d    = 1'b1;
                        mmr_we_d    = req_we;
                        mmr_sel_d   = req_sel;
                        mmr_wdata_d = req_wdata;
                    end else begin
                        state_d   = RESP;
                        cpu_ack_d = !pick_dma;
                        cpu_err_d = !pick_dma;
                        dma_ack_d = pick_dma;
                        dma_err_d = pick_dma;
                        if (err_count_q != 8'hFF) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                    end
                end
            end
            ACCESS: begin
                state_d   = RESP;
                cpu_ack_d = !gnt_q;
                dma_ack_d = gnt_q;
                if (!mmr_we_q) begin
                    cpu_rdata_d = gnt_q ? '0 : mmr_rdata;
                    dma_rdata_d = gnt_q ? mmr_rdata : '0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            gnt_q       <= 1'b0;
            mmr_en_q    <= 1'b0;
            mmr_we_q    <= 1'b0;
            mmr_sel_q   <= '0;
            mmr_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_ack_q   <= 1'b0;
            dma_err_q   <= 1'b0;
            dma_rdata_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            mmr_en_q    <= mmr_en_d;
            mmr_we_q    <= mmr_we_d;
            mmr_sel_q   <= mmr_sel_d;
            mmr_wdata_q <= mmr_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_err_q   <= cpu_err_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_ack_q   <= dma_ack_d;
            dma_err_q   <= dma_err_d;
            dma_rdata_q <= dma_rdata_d;
            err_count_q <= err_count_d;
        end
    end

    assign mmr_en    = mmr_en_q;
    assign mmr_we    = mmr_we_q;
    assign mmr_sel   = mmr_sel_q;
    assign mmr_wdata = mmr_wdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_err   = cpu_err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_ack   = dma_ack_q;
    assign dma_err   = dma_err_q;
    assign dma_rdata = dma_rdata_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_m_mmr_arbiter.sv
// Directed bench for m_mmr_arbiter with a small register-file model on the MMR side.
module tb_m_mmr_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [11:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack, cpu_err;
    logic [15:0] cpu_rdata;
    logic        dma_req, dma_we;
    logic [11:0] dma_addr;
    logic [15:0] dma_wdata;
    logic        dma_ack, dma_err;
    logic [15:0] dma_rdata;
    logic        mmr_en, mmr_we;
    logic [6:0]  mmr_sel;
    logic [15:0] mmr_wdata;
    logic [15:0] mmr_rdata;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_errors = 0;
    int en_count = 0;

    logic [15:0] regs [0:127];
    logic        init_done = 1'b0;

    m_mmr_arbiter #(
        .AW(12), .DW(16), .MMR_BASE(1025), .MMR_COUNT(75), .SW(7)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_err(dma_err), .dma_rdata(dma_rdata),
        .mmr_en(mmr_en), .mmr_we(mmr_we), .mmr_sel(mmr_sel), .mmr_wdata(mmr_wdata),
        .mmr_rdata(mmr_rdata), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: preset to 0x0100+index, written on strobed writes
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 128; i++) regs[i] <= 16'h0100 + 16'(i);
            init_done <= 1'b1;
        end else if (mmr_en && mmr_we) begin
            regs[mmr_sel] <= mmr_wdata;
        end
    end
    assign mmr_rdata = regs[mmr_sel];

    always @(negedge clk) if (mmr_en) en_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_access(input bit port, input bit we, input int addr,
                             input logic [15:0] wd, input logic [15:0] exp_rd);
        bit in_range;
        in_range = (addr >= 1025) && (addr <= 1099);
        @(negedge clk);
        if (port) begin
            dma_req = 1'b1; dma_we = we; dma_addr = 12'(addr); dma_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = 12'(addr); cpu_wdata = wd;
        end
        @(negedge clk);
        if (in_range) begin
            check("acc_en", 32'(mmr_en), 32'd1);
            check("acc_sel", 32'(mmr_sel), 32'(addr - 1025));
            check("acc_we", 32'(mmr_we), 32'(we));
            if (we) check("acc_wdata", 32'(mmr_wdata), 32'(wd));
            check("acc_noack", 32'({cpu_ack, dma_ack}), 32'd0);
            @(negedge clk);
            check("rsp_en", 32'(mmr_en), 32'd0);
            check("rsp_err", 32'({cpu_err, dma_err}), 32'd0);
        end else begin
            check("oor_en", 32'(mmr_en), 32'd0);
            check("oor_err", 32'({cpu_err, dma_err}), port ? 32'd1 : 32'd2);
        end
        check("rsp_ack", 32'({cpu_ack, dma_ack}), port ? 32'd1 : 32'd2);
        check("rsp_rdata", 32'(port ? dma_rdata : cpu_rdata),
              32'((we || !in_range) ? 16'h0000 : exp_rd));
        cpu_req = 1'b0;
        dma_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int acks;
        int en_before;
        logic [15:0] exp;

        rst_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'd1030; cpu_wdata = 16'hFFFF;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 12'd1030; dma_wdata = 16'hFFFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_ctl", 32'({cpu_ack, cpu_err, dma_ack, dma_err, mmr_en, mmr_we}), 32'd0);
            check("rst_rdata", {cpu_rdata, dma_rdata}, 32'd0);
            check("rst_mmr", 32'({mmr_sel, mmr_wdata}), 32'd0);
            check("rst_errcnt", 32'(err_count), 32'd0);
        end
        rst_n = 1'b1;
        cpu_req = 1'b0;
        dma_req = 1'b0;

        do_access(1'b0, 1'b1, 1025, 16'hA5A5, 16'h0000);
        do_access(1'b0, 1'b0, 1025, 16'h0000, 16'hA5A5);
        do_access(1'b0, 1'b1, 1099, 16'h1234, 16'h0000);
        do_access(1'b0, 1'b0, 1099, 16'h0000, 16'h1234);

        for (int a = 1025; a <= 1099; a++) begin
            exp = (a == 1025) ? 16'hA5A5 : (a == 1099) ? 16'h1234 : 16'h0100 + 16'(a - 1025);
            do_access(1'b0, 1'b0, a, 16'h0000, exp);
        end

        en_before = en_count;
        do_access(1'b0, 1'b0, 1024, 16'h0000, 16'h0000);
        do_access(1'b0, 1'b1, 1100, 16'hDEAD, 16'h0000);
        do_access(1'b1, 1'b0, 4095, 16'h0000, 16'h0000);
        check("oor_no_strobe", 32'(en_count - en_before), 32'd0);
        check("oor_errcnt", 32'(err_count), 32'd3);

        // DMA write leaves the pointer on CPU for the contention run
        do_access(1'b1, 1'b1, 1040, 16'hBEEF, 16'h0000);

        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd1030;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 12'd1040;
        acks = 0;
        for (int c = 1; c <= 24 && acks < 6; c++) begin
            @(negedge clk);
            if (cpu_ack || dma_ack) begin
                check("arb_both", 32'(cpu_ack & dma_ack), 32'd0);
                check("arb_cycle", 32'(c), 32'(2 + 3 * acks));
                check("arb_port", 32'(dma_ack), 32'(acks % 2));
                check("arb_rdata", 32'(dma_ack ? dma_rdata : cpu_rdata),
                      (acks % 2) ? 32'h0000_BEEF : 32'h0000_0105);
                acks++;
                if (acks == 6) begin
                    cpu_req = 1'b0;
                    dma_req = 1'b0;
                end
            end
        end
        check("arb_count", 32'(acks), 32'd6);
        cpu_req = 1'b0;
        dma_req = 1'b0;

        @(negedge clk);
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 12'd1040;
        @(negedge clk);
        check("abort_in_access", 32'(mmr_en), 32'd1);
        rst_n = 1'b0;
        dma_req = 1'b0;
        @(negedge clk);
        check("abort_noack", 32'({cpu_ack, dma_ack, mmr_en}), 32'd0);
        check("abort_errcnt", 32'(err_count), 32'd0);
        @(negedge clk);
        check("abort_noack2", 32'({cpu_ack, dma_ack}), 32'd0);
        rst_n = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd1030;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 12'd1040;
        @(negedge clk);
        check("post_rst_en", 32'(mmr_en), 32'd1);
        check("post_rst_sel", 32'(mmr_sel), 32'd5);
        @(negedge clk);
        check("post_rst_ack", 32'({cpu_ack, dma_ack}), 32'd2);
        check("post_rst_rdata", 32'(cpu_rdata), 32'h0000_0105);
        cpu_req = 1'b0;
        dma_req = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
